// File: rtl/dbus_arbiter.sv
// Two-master D-bus arbiter: registered round-robin grant, core-halted priority for m1,
// and a per-transaction response timeout that terminates a stuck transfer with an error.
module dbus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_halted,
    input  logic        m0_bstart,
    input  logic [31:0] m0_addr,
    input  logic        m0_ttype,
    input  logic [1:0]  m0_tsize,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_bdone,
    output logic        m0_berr,
    input  logic        m1_bstart,
    input  logic [31:0] m1_addr,
    input  logic        m1_ttype,
    input  logic [1:0]  m1_tsize,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_bdone,
    output logic        m1_berr,
    output logic        s_bstart,
    output logic [31:0] s_addr,
    output logic        s_ttype,
    output logic [1:0]  s_tsize,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_bdone,
    output logic [1:0]  grant
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
    logic             finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        timeout  = 1'b0;
        finish   = 1'b0;
        s_bstart = 1'b0;
        s_addr   = 32'h0;
        s_ttype  = 1'b0;
        s_tsize  = 2'b00;
        s_wdata  = 32'h0;
        m0_bdone = 1'b0;
        m0_berr  = 1'b0;
        m0_rdata = 32'h0;
        m1_bdone = 1'b0;
        m1_berr  = 1'b0;
        m1_rdata = 32'h0;
        case (state_q)
            IDLE: begin
                if (m0_bstart || m1_bstart) begin
                    // Halted-core priority first, then lone requester, then round-robin on last
                    if (core_halted && m1_bstart)
                        grant_d = 2'b10;
                    else if (m0_bstart && !m1_bstart)
                        grant_d = 2'b01;
                    else if (m1_bstart && !m0_bstart)
                        grant_d = 2'b10;
                    else
                        grant_d = last_q ? 2'b01 : 2'b10;
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                s_bstart = 1'b1;
                if (grant_q[1]) begin
                    s_addr  = m1_addr;
                    s_ttype = m1_ttype;
                    s_tsize = m1_tsize;
                    s_wdata = m1_wdata;
                end else begin
                    s_addr  = m0_addr;
                    s_ttype = m0_ttype;
                    s_tsize = m0_tsize;
                    s_wdata = m0_wdata;
                end
                // A slave response in the timeout cycle wins over the timeout
                timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !s_bdone;
                finish  = s_bdone || timeout;
                if (finish) begin
                    m0_bdone = grant_q[0];
                    m1_bdone = grant_q[1];
                    m0_berr  = grant_q[0] && timeout;
                    m1_berr  = grant_q[1] && timeout;
                    m0_rdata = (grant_q[0] && s_bdone) ? s_rdata : 32'h0;
                    m1_rdata = (grant_q[1] && s_bdone) ? s_rdata : 32'h0;
                    state_d  = IDLE;
                    grant_d  = 2'b00;
                    last_d   = grant_q[1];
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant = grant_q;

    // The granted master must keep its request up until its bdone
    assert property (@(posedge clk) disable iff (!rst_n)
                     (state_q == BUSY) |-> |(grant_q & {m1_bstart, m0_bstart}));

endmodule
